requant_scheduler: RTL and testbench
====================================

Name: requant_scheduler

Overview:
- Shares one pipelined requantization datapath between N_LANES accumulator lanes of a quantized linear layer.
- Round-robin arbitration with per-lane valid/ready handshake, per-lane bias register file, tagged 8-bit output stream with backpressure.
- Counts emitted results and pulses a layer-done flag.
- Sits between the MAC lane array and the activation writeback.

Parameters:
- N_LANES, 4, number of requesting accumulator lanes (2..16).
- Z_WEIGHTS, 5, weight zero-point subtracted as Z_WEIGHTS*ai.
- M_MUL, 2094967296, fixed-point multiplier, unsigned 32-bit (Q0.32).
- BIAS_PRECISION, 32, width of acc, ai, bias (signed).
- OUTPUT_STAGE_PRECISION, 64, internal product width (signed).
- OUTS_PER_LAYER, 16, results per layer before layer_done pulses.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lane_valid  in  N_LANES  per-lane request.
- lane_acc  in  N_LANES*BIAS_PRECISION  packed accumulators, lane i at [i*32 +: 32].
- lane_ai  in  N_LANES*BIAS_PRECISION  packed activation sums.
- lane_ready  out  N_LANES  one-hot grant; transfer when lane_valid[i] & lane_ready[i].
- cfg_we  in  1  bias write strobe.
- cfg_addr  in  $clog2(N_LANES)  bias entry index.
- cfg_bias  in  BIAS_PRECISION  bias value.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  8  requantized result.
- out_lane  out  $clog2(N_LANES)  source lane tag.
- layer_done  out  1  one-cycle pulse on the OUTS_PER_LAYER-th output transfer.

Behaviour:
- Reset (async assert, sync release):
  - out_valid, lane_ready, layer_done = 0.
  - out_data, out_lane = 0.
  - Pipeline valids cleared; RR pointer = 0; output counter = 0; bias table = 0.
  - Reset mid-operation discards in-flight results.
- advance = !out_valid | out_ready. All stages stall together when advance=0.
- Arbitration is combinational:
  - When advance=1, search lane_valid starting at pointer, wrapping modulo N_LANES.
  - First set bit gets lane_ready. When advance=0, lane_ready = 0.
  - On transfer from lane k, pointer <= (k+1) mod N_LANES. No transfer: pointer holds.
- S1 (transfer cycle): register acc, ai, bias[k] and tag k.
  - Bias is read before write: a cfg write to entry k in the same cycle is not seen. It is seen from the next grant.
- S2: diff = acc - Z_WEIGHTS*ai, sign-extended to 64 bits. prod = diff * M_MUL, M_MUL zero-extended. 64-bit wrap.
- S3: r = (prod >>> 32) + sign-extended bias. out_data = r[7:0] (truncation, no saturation). out_lane = tag. out_valid = 1.
- Latency: out_valid rises 3 cycles after the transfer edge. Throughput is 1 result/cycle with out_ready held high.
- out_valid, out_data and out_lane stay stable while out_valid & !out_ready.
- Counter increments on each output transfer (out_valid & out_ready).
  - On the transfer that reaches OUTS_PER_LAYER: layer_done = 1 for one cycle, counter -> 0.
- Invalid requests:
  - lane_valid = 0 on all lanes: no grant, bubble enters the pipeline.
  - cfg_addr >= N_LANES: write is ignored.

Test Plan:
- Single request: Z=5, M default, bias[1]=10. Lane 1 acc=1000, ai=10 -> diff 950, r=473, out_data=0xD9, out_lane=1, out_valid exactly 3 cycles after the transfer.
- Negative rounding: lane 0 acc=0, ai=10, bias 0 -> diff -50, floor(-24.39)=-25, out_data=0xE7.
- Round-robin: all 4 lanes valid continuously with out_ready=1 -> grants 0,1,2,3,0,... with one grant per cycle. Output tags follow the same order, 3 cycles later.
- Backpressure: out_ready=0 for 5 cycles with a result valid -> out_data and out_lane frozen, lane_ready=0, no result lost or duplicated. Order is preserved after release.
- Same-cycle bias write: cfg write bias[2]=100 in lane 2's grant cycle -> result uses the old bias. The next lane-2 result uses 100.
- Layer count and reset: 16 output transfers -> layer_done pulses on the 16th only. rst_n low mid-stream -> outputs 0 immediately, pointer 0, bias table 0.

Source files
------------

// File: rtl/requant_scheduler.sv
// rtl/requant_scheduler.sv - round-robin lane arbiter feeding one shared 3-stage requantization pipeline
// Produces tagged 8-bit results with backpressure and a per-layer completion pulse.
module requant_scheduler #(
   parameter int          N_LANES                = 4,
   parameter int          Z_WEIGHTS              = 5,
   parameter logic [31:0] M_MUL                  = 32'd2094967296,
   parameter int          BIAS_PRECISION         = 32,
   parameter int          OUTPUT_STAGE_PRECISION = 64,
   parameter int          OUTS_PER_LAYER         = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [N_LANES-1:0]                lane_valid,
   input  logic [N_LANES*BIAS_PRECISION-1:0] lane_acc,
   input  logic [N_LANES*BIAS_PRECISION-1:0] lane_ai,
   output logic [N_LANES-1:0]                lane_ready,
   input  logic                              cfg_we,
   input  logic [$clog2(N_LANES)-1:0]        cfg_addr,
   input  logic [BIAS_PRECISION-1:0]         cfg_bias,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [7:0]                        out_data,
   output logic [$clog2(N_LANES)-1:0]        out_lane,
   output logic                              layer_done
);
   localparam int AW = $clog2(N_LANES);
   localparam int BP = BIAS_PRECISION;
   localparam int OP = OUTPUT_STAGE_PRECISION;
   localparam int CW = $clog2(OUTS_PER_LAYER + 1);

   logic          advance, transfer;
   logic [AW-1:0] ptr, grant_idx, idx;
   logic          found;

   logic                 s1_v, s2_v;
   logic signed [BP-1:0] s1_acc, s1_ai, s1_bias, s2_bias;
   logic [AW-1:0]        s1_tag, s2_tag;
   logic signed [OP-1:0] diff, prod_c, s2_prod, r;
   logic signed [BP-1:0] bias_tbl [N_LANES];
   logic [CW-1:0]        out_cnt;
   logic                 out_xfer;
   logic                 unused_bits;

   assign advance  = !out_valid || out_ready;
   assign out_xfer = out_valid && out_ready;

   // Search starts at the pointer; rst_n gating keeps grants low while reset is held.
   always_comb begin
      lane_ready = '0;
      grant_idx  = '0;
      found      = 1'b0;
      idx        = '0;
      if (advance && rst_n) begin
         for (int o = 0; o < N_LANES; o++) begin
            idx = AW'((32'(ptr) + o) % N_LANES);
            if (!found && lane_valid[idx]) begin
               found          = 1'b1;
               lane_ready[idx] = 1'b1;
               grant_idx      = idx;
            end
         end
      end
   end

   assign transfer = found;

   assign diff   = OP'(s1_acc) - OP'(Z_WEIGHTS) * OP'(s1_ai);
   assign prod_c = diff * $signed({{(OP-32){1'b0}}, M_MUL});
   assign r      = (s2_prod >>> 32) + OP'(s2_bias);
   assign unused_bits = ^r[OP-1:8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         for (int i = 0; i < N_LANES; i++) bias_tbl[i] <= '0;
      end else begin
         if (cfg_we && (32'(cfg_addr) < N_LANES)) bias_tbl[cfg_addr] <= cfg_bias;
         if (transfer) ptr <= (grant_idx == AW'(N_LANES - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_acc    <= '0;
         s1_ai     <= '0;
         s1_bias   <= '0;
         s1_tag    <= '0;
         s2_v      <= 1'b0;
         s2_prod   <= '0;
         s2_bias   <= '0;
         s2_tag    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_lane  <= '0;
      end else if (advance) begin
         s1_v <= transfer;
         if (transfer) begin
            s1_acc  <= lane_acc[BP*grant_idx +: BP];
            s1_ai   <= lane_ai[BP*grant_idx +: BP];
            s1_bias <= bias_tbl[grant_idx];
            s1_tag  <= grant_idx;
         end
         s2_v <= s1_v;
         if (s1_v) begin
            s2_prod <= prod_c;
            s2_bias <= s1_bias;
            s2_tag  <= s1_tag;
         end
         out_valid <= s2_v;
         if (s2_v) begin
            out_data <= r[7:0];
            out_lane <= s2_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_cnt <= '0;
      else if (out_xfer) out_cnt <= (out_cnt == CW'(OUTS_PER_LAYER - 1)) ? '0 : out_cnt + 1'b1;
   end

   assign layer_done = out_xfer && (out_cnt == CW'(OUTS_PER_LAYER - 1));
endmodule

// File: tb/tb_requant_scheduler.sv
// tb/tb_requant_scheduler.sv - scoreboard bench for requant_scheduler
// Vector table, streaming round-robin, backpressure, bias hazard, layer count and reset.
module tb_requant_scheduler;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    lane_valid;
   logic [N*32-1:0] lane_acc, lane_ai;
   logic [N-1:0]    lane_ready;
   logic            cfg_we;
   logic [1:0]      cfg_addr;
   logic [31:0]     cfg_bias;
   logic            out_valid, out_ready, layer_done;
   logic [7:0]      out_data;
   logic [1:0]      out_lane;

   requant_scheduler dut (
      .clk(clk), .rst_n(rst_n), .lane_valid(lane_valid), .lane_acc(lane_acc), .lane_ai(lane_ai),
      .lane_ready(lane_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bias(cfg_bias),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
      .layer_done(layer_done)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] data; int lane; } exp_t;
   typedef struct { int lane; logic [31:0] acc; logic [31:0] ai; logic [31:0] bias; logic [7:0] exp; } vec_t;

   exp_t        sb[$];
   int          grants[$];
   logic [31:0] bias_m [N];
   int          ptr_m, cnt_m, done_pulses;
   logic [7:0]  last_data;
   int          checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [31:0] acc, input logic [31:0] ai, input logic [31:0] bias);
      longint d, p, rr;
      d  = longint'(signed'(acc)) - 64'sd5 * longint'(signed'(ai));
      p  = d * 64'sd2094967296;
      rr = (p >>> 32) + longint'(signed'(bias));
      return rr[7:0];
   endfunction

   task automatic model_reset();
      sb.delete();
      grants.delete();
      for (int i = 0; i < N; i++) bias_m[i] = '0;
      ptr_m = 0;
      cnt_m = 0;
      done_pulses = 0;
   endtask

   task automatic cycle();
      logic [N-1:0] eg;
      bit           f;
      int           k;
      exp_t         e;
      bit           ed;
      @(negedge clk);
      eg = '0;
      f  = 1'b0;
      if (!(out_valid && !out_ready)) begin
         for (int o = 0; o < N; o++) begin
            k = (ptr_m + o) % N;
            if (!f && lane_valid[k]) begin
               f = 1'b1;
               eg[k] = 1'b1;
            end
         end
      end
      chk("lane_ready", 64'(lane_ready), 64'(eg));
      for (int i = 0; i < N; i++) begin
         if (lane_valid[i] && lane_ready[i]) begin
            e.data = model(lane_acc[i*32 +: 32], lane_ai[i*32 +: 32], bias_m[i]);
            e.lane = i;
            sb.push_back(e);
            grants.push_back(i);
            ptr_m = (i + 1) % N;
         end
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 64'(out_data), 64'hDEAD);
         end else begin
            e = sb.pop_front();
            chk("out_data", 64'(out_data), 64'(e.data));
            chk("out_lane", 64'(out_lane), 64'(e.lane));
            last_data = out_data;
         end
         ed = (cnt_m == 15);
         cnt_m = ed ? 0 : cnt_m + 1;
         if (ed) done_pulses++;
         chk("layer_done", 64'(layer_done), 64'(ed));
      end else begin
         chk("layer_done_idle", 64'(layer_done), 64'd0);
      end
      if (cfg_we && int'(cfg_addr) < N) bias_m[cfg_addr] = cfg_bias;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int b;
      lane_valid = '0;
      cfg_we     = 1'b0;
      out_ready  = 1'b1;
      b = 0;
      while ((sb.size() != 0 || out_valid) && b < 20) begin
         cycle();
         b++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic set_lane(input int i, input logic [31:0] acc, input logic [31:0] ai);
      lane_acc[i*32 +: 32] = acc;
      lane_ai[i*32 +: 32]  = ai;
   endtask

   task automatic rand_lanes();
      for (int i = 0; i < N; i++) set_lane(i, $urandom, $urandom_range(0, 4000) - 2000);
   endtask

   task automatic write_bias(input int a, input logic [31:0] v);
      cfg_we   = 1'b1;
      cfg_addr = 2'(a);
      cfg_bias = v;
      cycle();
      cfg_we   = 1'b0;
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1, 32'd1000, 32'd10, 32'd10, 8'hD9};
      vecs[1] = '{0, 32'd0, 32'd10, 32'd0, 8'hE7};
      vecs[2] = '{2, 32'd0, 32'd0, 32'h7F, 8'h7F};
      vecs[3] = '{3, 32'd5, 32'd1, 32'hFFFF_FFFF, 8'hFF};
      vecs[4] = '{0, 32'h7FFF_FFFF, 32'd0, 32'd1, 8'h00};
      vecs[5] = '{1, 32'd0, 32'hFFFF_FFF6, 32'd0, 8'h18};

      rst_n = 1'b0; lane_valid = '0; lane_acc = '0; lane_ai = '0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0; out_ready = 1'b1;
      model_reset();
      #22;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_lane", 64'(out_lane), 64'd0);
      chk("rst_layer_done", 64'(layer_done), 64'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: result appears in the third cycle counting the transfer cycle.
      write_bias(1, 32'd10);
      set_lane(1, 32'd1000, 32'd10);
      lane_valid = 4'b0010;
      cycle();
      lane_valid = '0;
      chk("lat_c1", 64'(out_valid), 64'd0);
      cycle();
      chk("lat_c2", 64'(out_valid), 64'd0);
      cycle();
      chk("lat_c3", 64'(out_valid), 64'd1);
      chk("lat_data", 64'(out_data), 64'hD9);
      chk("lat_lane", 64'(out_lane), 64'd1);
      drain();

      for (int v = 0; v < 6; v++) begin
         write_bias(vecs[v].lane, vecs[v].bias);
         set_lane(vecs[v].lane, vecs[v].acc, vecs[v].ai);
         lane_valid = 4'(1 << vecs[v].lane);
         cycle();
         drain();
         chk($sformatf("vec%0d_data", v), 64'(last_data), 64'(vecs[v].exp));
      end

      // Bias written in lane 2's grant cycle is not seen by that grant.
      write_bias(2, 32'd7);
      set_lane(2, 32'd1000, 32'd10);
      lane_valid = 4'b0100;
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_bias = 32'd100;
      cycle();
      drain();
      chk("bias_old", 64'(last_data), 64'hD6);
      lane_valid = 4'b0100;
      cycle();
      drain();
      chk("bias_new", 64'(last_data), 64'h33);

      // Round-robin with every lane requesting.
      grants.delete();
      lane_valid = 4'b1111;
      for (int c = 0; c < 12; c++) begin
         rand_lanes();
         cycle();
      end
      chk("rr_count", 64'(grants.size()), 64'd12);
      for (int g = 1; g < grants.size(); g++)
         chk("rr_order", 64'(grants[g]), 64'((grants[g-1] + 1) % N));

      // Backpressure: outputs frozen, no grants, nothing lost.
      begin
         logic [7:0] hd;
         logic [1:0] hl;
         out_ready = 1'b0;
         cycle();
         hd = out_data;
         hl = out_lane;
         for (int c = 0; c < 5; c++) begin
            rand_lanes();
            cycle();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", 64'(out_data), 64'(hd));
            chk("bp_lane", 64'(out_lane), 64'(hl));
         end
         out_ready = 1'b1;
         for (int c = 0; c < 4; c++) begin
            rand_lanes();
            cycle();
         end
         drain();
      end

      // Mid-stream reset.
      lane_valid = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         rand_lanes();
         cycle();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 64'(out_valid), 64'd0);
      chk("mrst_out_data", 64'(out_data), 64'd0);
      chk("mrst_lane_ready", 64'(lane_ready), 64'd0);
      model_reset();
      lane_valid = '0;
      @(posedge clk); #1; rst_n = 1'b1;
      lane_valid = 4'b1111;
      rand_lanes();
      cycle();
      chk("mrst_first_grant", 64'(grants[0]), 64'd0);
      drain();
      set_lane(1, 32'd1000, 32'd10);
      lane_valid = 4'b0010;
      cycle();
      drain();
      chk("mrst_bias_zero", 64'(last_data), 64'hCF);

      // Layer count: 2 outputs so far; 14 more reach the 16th transfer.
      lane_valid = 4'b1111;
      for (int c = 0; c < 14; c++) begin
         rand_lanes();
         cycle();
      end
      drain();
      chk("layer_pulses", 64'(done_pulses), 64'd1);
      chk("layer_cnt", 64'(cnt_m), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
